uart_rx_v2: RTL and testbench

UART receiver that consumes the serial stream driven by the SoC's UART transmit pin (io_uart_txd) and turns it into bytes. It is the receive-side counterpart of uart_tx_v2 in the same line clock domain. A 16x-oversampling front end with majority voting feeds a small show-ahead byte FIFO, so the bench or FPGA top can drain console output without per-byte timing pressure.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/uart_rx_v2.sv | 132 +++++++++++++
 tb/tb_uart_rx_v2.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, oversampling ratio and the
// mid-bit sample points used for majority voting.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rxState_e;

    localparam int OVS   = 16;
    localparam int OVS_W = $clog2(OVS);

    localparam logic [OVS_W-1:0] SMP_FIRST = OVS_W'(7);
    localparam logic [OVS_W-1:0] SMP_MID   = OVS_W'(8);
    localparam logic [OVS_W-1:0] SMP_LAST  = OVS_W'(9);
    localparam logic [OVS_W-1:0] OVS_LAST  = OVS_W'(OVS - 1);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: rdData always presents the head entry, and an
// extra pointer MSB distinguishes full from empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wrEn,
    input  logic [WIDTH-1:0] wrData,
    input  logic             rdEn,
    output logic [WIDTH-1:0] rdData,
    output logic             empty,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full;
    logic             doPush;
    logic             doPop;

    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doPop  = rdEn && !empty;
    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign doPush = wrEn && (!full || doPop);
    assign rdData = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            overflow <= wrEn && full && !doPop;
            if (doPush) begin
                mem[wrPtr[AW-1:0]] <= wrData;
                wrPtr              <= wrPtr + (AW+1)'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_v2.sv
// UART receiver: 2-flop synchronizer, 16x oversampling with 3-sample majority
// voting per bit, and a show-ahead byte FIFO toward the consumer.
module uart_rx_v2
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_p,
    output logic [7:0] dout,
    output logic       rx_valid,
    input  logic       rd_en,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV   = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
    localparam int DIV_W = $clog2(DIV) + 1;

    rxState_e         state;
    logic             rxMeta;
    logic             rxs;
    logic [DIV_W-1:0] divCnt;
    logic [OVS_W-1:0] sampleCnt;
    logic [2:0]       bitIdx;
    logic [7:0]       shiftReg;
    logic             smp7;
    logic             smp8;
    logic             pushEn;
    logic [7:0]       pushData;
    logic             frameErr;
    logic             fifoEmpty;
    logic             tick;
    logic             maj;

    assign tick = (divCnt == DIV_W'(DIV - 1));
    assign maj  = maj3(smp7, smp8, rxs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxMeta <= 1'b1;
            rxs    <= 1'b1;
        end else begin
            rxMeta <= rx_p;
            rxs    <= rxMeta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            divCnt    <= '0;
            sampleCnt <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
            smp7      <= 1'b1;
            smp8      <= 1'b1;
            pushEn    <= 1'b0;
            pushData  <= '0;
            frameErr  <= 1'b0;
        end else begin
            pushEn   <= 1'b0;
            frameErr <= 1'b0;
            divCnt   <= tick ? '0 : divCnt + DIV_W'(1);
            if (tick && sampleCnt == SMP_FIRST) smp7 <= rxs;
            if (tick && sampleCnt == SMP_MID)   smp8 <= rxs;
            if (tick) sampleCnt <= sampleCnt + OVS_W'(1);

            unique case (state)
                IDLE: begin
                    sampleCnt <= '0;
                    // Restarting the divider here phase-locks sampling to the start edge.
                    if (!rxs) begin
                        state  <= START;
                        divCnt <= '0;
                    end
                end
                START: if (tick) begin
                    if (sampleCnt == SMP_LAST && maj) begin
                        state <= IDLE;
                    end else if (sampleCnt == OVS_LAST) begin
                        state  <= DATA;
                        bitIdx <= '0;
                    end
                end
                DATA: if (tick) begin
                    if (sampleCnt == SMP_LAST) shiftReg <= {maj, shiftReg[7:1]};
                    if (sampleCnt == OVS_LAST) begin
                        if (bitIdx == 3'd7) state  <= STOP;
                        else                bitIdx <= bitIdx + 3'd1;
                    end
                end
                STOP: if (tick && sampleCnt == SMP_LAST) begin
                    // Leaving mid stop bit lets a back-to-back start edge be caught.
                    if (maj) begin
                        pushEn   <= 1'b1;
                        pushData <= shiftReg;
                        state    <= IDLE;
                    end else begin
                        frameErr <= 1'b1;
                        state    <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: if (rxs) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Consumer handshake: a byte transfers on every clk edge where rx_valid and
    // rd_en are both high; dout holds the head byte steady until then.
    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) rxFifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wrEn     (pushEn),
        .wrData   (pushData),
        .rdEn     (rd_en),
        .rdData   (dout),
        .empty    (fifoEmpty),
        .overflow (overrun)
    );

    assign rx_valid  = !fifoEmpty;
    assign frame_err = frameErr;

endmodule

// File: tb/tb_uart_rx_v2.sv
// Self-checking bench for uart_rx_v2: a table of framed bytes plus hand-built
// sequences for glitches, breaks, overrun, back-to-back traffic and reset.
module tb_uart_rx_v2;

    // A faster line rate keeps the run short; the oversampling arithmetic is unchanged.
    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 390_625;
    localparam int DIV_TB   = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
    localparam int BIT_CLK  = 16 * DIV_TB;
    localparam int EXP_LAT  = (9 * 16 + 10) * DIV_TB + 4;
    localparam int WAIT_MAX = 20 * BIT_CLK;

    logic       clk;
    logic       rst_n;
    logic       rx_p;
    logic       rd_en;
    logic [7:0] dout;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    logic [7:0] exp_q[$];
    int total    = 0;
    int bad      = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       exp_push;
        int         exp_ferr;
    } vec_t;
    vec_t vecs[6];

    uart_rx_v2 #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_p      (rx_p),
        .dout      (dout),
        .rx_valid  (rx_valid),
        .rd_en     (rd_en),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(negedge clk) begin
        if (frame_err) ferr_cnt++;
        if (overrun)   ovr_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Driver: start bit, 8 data bits LSB first, stop bit; leaves the line at the stop value.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rx_p = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx_p = d[i];
            wait_clk(BIT_CLK);
        end
        rx_p = stop_bit;
        wait_clk(BIT_CLK);
    endtask

    // Scoreboard: wait for a byte, compare with the queue head, pop it from the DUT.
    task automatic pop_check(input string name);
        int n;
        logic [7:0] e;
        n = 0;
        while (!rx_valid && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        if (!rx_valid) begin
            check({name, "_timeout"}, 32'(rx_valid), 32'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            check({name, "_unexpected"}, 32'(dout), 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check(name, 32'(dout), 32'(e));
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        int base_f;
        int base_o;
        int lat;

        rst_n = 1'b0;
        rx_p  = 1'b1;
        rd_en = 1'b0;

        vecs[0] = '{8'h41, 1'b1, 1'b1, 0};
        vecs[1] = '{8'h5A, 1'b1, 1'b1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 0};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 0};
        vecs[4] = '{8'h3C, 1'b0, 1'b0, 1};
        vecs[5] = '{8'hA5, 1'b1, 1'b1, 0};

        wait_clk(5);
        check("reset_rx_valid",  32'(rx_valid),  32'd0);
        check("reset_dout",      32'(dout),      32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_overrun",   32'(overrun),   32'd0);
        rst_n = 1'b1;
        wait_clk(20);

        // First byte and start-edge-to-rx_valid latency
        exp_q.push_back(8'h41);
        lat = 0;
        fork
            send_frame(8'h41, 1'b1);
            begin
                while (!rx_valid && lat < WAIT_MAX) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        total++;
        if (lat < EXP_LAT - 3 || lat > EXP_LAT + 3) begin
            bad++;
            $display("FAIL first_latency: got %0d clk expected %0d +/-3", lat, EXP_LAT);
        end
        pop_check("first_byte");
        check("first_empty_after_pop", 32'(rx_valid), 32'd0);
        wait_clk(BIT_CLK);

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            base_f = ferr_cnt;
            if (vecs[i].exp_push) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop_bit);
            rx_p = 1'b1;
            wait_clk(2 * BIT_CLK);
            check($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - base_f), 32'(vecs[i].exp_ferr));
            if (vecs[i].exp_push) pop_check($sformatf("vec%0d_data", i));
            check($sformatf("vec%0d_empty", i), 32'(rx_valid), 32'd0);
        end

        // Short low glitch is rejected as a false start
        base_f = ferr_cnt;
        rx_p = 1'b0;
        wait_clk(BIT_CLK / 4);
        rx_p = 1'b1;
        wait_clk(2 * BIT_CLK);
        check("glitch_no_ferr",  32'(ferr_cnt - base_f), 32'd0);
        check("glitch_no_valid", 32'(rx_valid), 32'd0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        pop_check("after_glitch");

        // Bad stop bit followed by a break: one frame_err, byte dropped
        wait_clk(BIT_CLK);
        base_f = ferr_cnt;
        send_frame(8'h33, 1'b0);
        wait_clk(2000);
        rx_p = 1'b1;
        wait_clk(2 * BIT_CLK);
        check("break_one_ferr", 32'(ferr_cnt - base_f), 32'd1);
        check("break_no_valid", 32'(rx_valid), 32'd0);
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1);
        wait_clk(BIT_CLK);
        pop_check("after_break");
        check("after_break_empty", 32'(rx_valid), 32'd0);

        // 17 back-to-back bytes with no reads: the 17th overruns
        base_o = ovr_cnt;
        for (int b = 0; b < 17; b++) begin
            if (b < 16) exp_q.push_back(8'(b));
            send_frame(8'(b), 1'b1);
        end
        wait_clk(2 * BIT_CLK);
        check("overrun_once", 32'(ovr_cnt - base_o), 32'd1);
        check("full_valid",   32'(rx_valid), 32'd1);
        for (int b = 0; b < 16; b++) begin
            pop_check($sformatf("drain_%0d", b));
        end
        check("drain_empty", 32'(rx_valid), 32'd0);

        // Back-to-back stream while the consumer pops every byte
        base_f = ferr_cnt;
        base_o = ovr_cnt;
        for (int b = 0; b < 6; b++) exp_q.push_back(8'h41 + 8'(b));
        fork
            begin
                for (int b = 0; b < 6; b++) send_frame(8'h41 + 8'(b), 1'b1);
            end
            begin
                for (int b = 0; b < 6; b++) pop_check($sformatf("stream_%0d", b));
            end
        join
        wait_clk(2 * BIT_CLK);
        check("stream_no_ferr", 32'(ferr_cnt - base_f), 32'd0);
        check("stream_no_ovr",  32'(ovr_cnt - base_o), 32'd0);
        check("stream_empty",   32'(rx_valid), 32'd0);

        // Reset during bit 3 of a frame with two bytes buffered
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_clk(BIT_CLK);
        check("buffered_valid", 32'(rx_valid), 32'd1);
        rx_p = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 3; i++) begin
            rx_p = 1'(8'h99 >> i);
            wait_clk(BIT_CLK);
        end
        rx_p = 1'b1;
        wait_clk(BIT_CLK / 2);
        rst_n = 1'b0;
        #1;
        check("midreset_valid", 32'(rx_valid), 32'd0);
        check("midreset_dout",  32'(dout),     32'd0);
        wait_clk(10);
        rst_n = 1'b1;
        base_f = ferr_cnt;
        wait_clk(2 * BIT_CLK);
        check("postreset_valid", 32'(rx_valid), 32'd0);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        pop_check("postreset_byte");
        wait_clk(BIT_CLK);
        check("postreset_empty", 32'(rx_valid), 32'd0);
        check("postreset_ferr",  32'(ferr_cnt - base_f), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
